// File: rtl/hc595_frame_shifter_if.sv
// Frame handshake from the digit scanner plus the 74HC595 pin bundle.
interface hc595_frame_shifter_if;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic       shcp;
  logic       stcp;
  logic       ds;
  logic       oe;
  logic       done;

  modport master (
    output seg, sel, in_valid,
    input  in_ready, shcp, stcp, ds, oe, done
  );

  modport slave (
    input  seg, sel, in_valid,
    output in_ready, shcp, stcp, ds, oe, done
  );
endinterface

// File: rtl/hc595_frame_shifter.sv
// Serializes one {seg, sel} frame MSB-first into two cascaded 74HC595s,
// then latches it with an stcp pulse and enables the outputs.
module hc595_frame_shifter #(
  parameter int unsigned HALF    = 2,
  parameter int unsigned FRAME_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hc595_frame_shifter_if.slave bus
);

  localparam int unsigned PH_W = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
  localparam int unsigned B_W  = $clog2(FRAME_W);

  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(2 * HALF - 1);
  localparam logic [PH_W-1:0] PH_HALF    = PH_W'(HALF);
  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(HALF - 1);
  localparam logic [B_W-1:0]  B_LAST     = B_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               shcp_q, shcp_d;
  logic               stcp_q, stcp_d;
  logic               ds_q, ds_d;
  logic               oe_q, oe_d;
  logic               done_q, done_d;
  logic               rdy_q, rdy_d;
  logic [FRAME_W-1:0] frame_in;

  assign frame_in = FRAME_W'({bus.seg, bus.sel});

  // State, shadow frame, counters and all pin registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      b_q     <= '0;
      ph_q    <= '0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      ds_q    <= 1'b0;
      oe_q    <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      b_q     <= b_d;
      ph_q    <= ph_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      ds_q    <= ds_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next state; pin values are derived from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    b_d     = b_q;
    ph_d    = ph_q;
    ds_d    = ds_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && rdy_q) begin
          state_d = SHIFT;
          frame_d = frame_in;
          b_d     = '0;
          ph_d    = '0;
          ds_d    = frame_in[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (b_q == B_LAST) begin
            state_d = LATCH;
          end else begin
            // Shadow shifts left so the next bit to send is always at the MSB
            b_d     = b_q + B_W'(1);
            frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            ds_d    = frame_q[FRAME_W-2];
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      LATCH: begin
        if (ph_q == LATCH_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    shcp_d = (state_d == SHIFT) && (ph_d >= PH_HALF);
    stcp_d = (state_d == LATCH);
    oe_d   = oe_q && (state_d != LATCH);
    done_d = (state_q == LATCH) && (state_d == IDLE);
    rdy_d  = (state_d == IDLE);
  end

  assign bus.in_ready = rdy_q;
  assign bus.shcp     = shcp_q;
  assign bus.stcp     = stcp_q;
  assign bus.ds       = ds_q;
  assign bus.oe       = oe_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_hc595_frame_shifter.sv
// Scoreboard bench: drivers queue expected bits/latch/done times, a negedge
// monitor pops and compares as the pins toggle. Instance a: HALF=2, b: HALF=1.
module tb_hc595_frame_shifter;
  localparam int unsigned HA = 2;
  localparam int unsigned HB = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hc595_frame_shifter_if ifa ();
  hc595_frame_shifter_if ifb ();

  hc595_frame_shifter #(.HALF(HA), .FRAME_W(14)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  hc595_frame_shifter #(.HALF(HB), .FRAME_W(14)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic exp_bits  [2][$];
  int   exp_latch [2][$];
  int   exp_done  [2][$];
  logic p_shcp[2], p_stcp[2], p_oe[2], first[2];
  int   nbits[2], nrise[2], nlatch[2], st_w[2];
  int   last_sh[2], last_rise[2], prev_rise[2];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(int i, logic shcp, logic stcp, logic ds, logic oe, logic done);
    int h;
    h = (i == 0) ? int'(HA) : int'(HB);
    if (!rst_n) begin
      p_shcp[i] = 1'b0; p_stcp[i] = 1'b0; p_oe[i] = 1'b1; first[i] = 1'b1;
      nbits[i] = 0; st_w[i] = 0;
      return;
    end
    if (shcp && !p_shcp[i]) begin
      nrise[i]++;
      nbits[i]++;
      if (nbits[i] > 1) chk("shcp_period", cyc - last_sh[i], 2 * h);
      last_sh[i] = cyc;
      chk("shcp_expected", int'(exp_bits[i].size() > 0), 1);
      if (exp_bits[i].size() > 0) chk("ds_bit", int'(ds), int'(exp_bits[i].pop_front()));
    end
    if (stcp && !p_stcp[i]) begin
      nlatch[i]++;
      chk("bits_before_latch", nbits[i], 14);
      nbits[i] = 0;
      chk("oe_low_first_stcp", int'(oe), 0);
      if (first[i]) chk("oe_high_before_latch", int'(p_oe[i]), 1);
      first[i] = 1'b0;
      chk("stcp_expected", int'(exp_latch[i].size() > 0), 1);
      if (exp_latch[i].size() > 0) chk("stcp_rise_cycle", cyc, exp_latch[i].pop_front());
      prev_rise[i] = last_rise[i];
      last_rise[i] = cyc;
      st_w[i] = 0;
    end
    if (stcp) st_w[i]++;
    if (!stcp && p_stcp[i]) chk("stcp_width", st_w[i], h);
    if (done) begin
      chk("done_expected", int'(exp_done[i].size() > 0), 1);
      if (exp_done[i].size() > 0) chk("done_cycle", cyc, exp_done[i].pop_front());
    end
    p_shcp[i] = shcp;
    p_stcp[i] = stcp;
    p_oe[i]   = oe;
  endtask

  always @(negedge clk) begin
    mon(0, ifa.shcp, ifa.stcp, ifa.ds, ifa.oe, ifa.done);
    mon(1, ifb.shcp, ifb.stcp, ifb.ds, ifb.oe, ifb.done);
  end

  task automatic drive(int i, logic [7:0] s, logic [5:0] d, logic v);
    if (i == 0) begin ifa.seg = s; ifa.sel = d; ifa.in_valid = v; end
    else        begin ifb.seg = s; ifb.sel = d; ifb.in_valid = v; end
  endtask

  function automatic logic rdy(int i);
    return (i == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  // Called in the low clock phase; returns in the low phase after the accept edge
  task automatic send(int i, logic [7:0] s, logic [5:0] d, output int acc);
    logic [13:0] f;
    int h;
    f = {s, d};
    h = (i == 0) ? int'(HA) : int'(HB);
    drive(i, s, d, 1'b1);
    for (int n = 0; n < 200 && !rdy(i); n++) @(negedge clk);
    chk("in_ready_at_accept", int'(rdy(i)), 1);
    acc = cyc;
    if (rdy(i)) begin
      for (int b = 13; b >= 0; b--) exp_bits[i].push_back(f[b]);
      exp_latch[i].push_back(cyc + 28 * h + 1);
      exp_done[i].push_back(cyc + 29 * h + 1);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(int i);
    for (int n = 0; n < 400 && exp_done[i].size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("frame_completed", exp_done[i].size(), 0);
  endtask

  task automatic chk_reset_pins(string tag);
    chk({tag, "_shcp"},  int'(ifa.shcp), 0);
    chk({tag, "_stcp"},  int'(ifa.stcp), 0);
    chk({tag, "_ds"},    int'(ifa.ds), 0);
    chk({tag, "_oe"},    int'(ifa.oe), 1);
    chk({tag, "_done"},  int'(ifa.done), 0);
    chk({tag, "_ready"}, int'(ifa.in_ready), 1);
  endtask

  initial begin
    int acc1, acc2, l0, base;
    rst_n = 1'b0;
    drive(0, 8'hA5, 6'b101010, 1'b1);
    drive(1, 8'h00, 6'b000000, 1'b0);

    // Reset held with in_valid high: nothing may be accepted
    repeat (4) @(negedge clk);
    chk_reset_pins("rst");
    drive(0, 8'hA5, 6'b101010, 1'b0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", int'(ifa.in_ready), 1);
    chk("post_rst_shcp", int'(ifa.shcp), 0);

    // Single frame: ds on shcp rises must read 1,0,1,0,0,1,0,1,1,0,1,0,1,0
    send(0, 8'hA5, 6'b101010, acc1);
    drive(0, 8'hA5, 6'b101010, 1'b0);
    wait_done(0);

    // Back-to-back: second accept lands in the done cycle, period 29*HALF+1
    send(0, 8'hFF, 6'b000001, acc1);
    send(0, 8'h03, 6'b100000, acc2);
    drive(0, 8'h03, 6'b100000, 1'b0);
    chk("b2b_accept_in_done_cycle", acc2 - acc1, 29 * int'(HA) + 1);
    wait_done(0);
    chk("b2b_stcp_spacing", last_rise[0] - prev_rise[0], 29 * int'(HA) + 1);

    // Busy: new data and an in_valid pulse during SHIFT are ignored
    l0 = nlatch[0];
    send(0, 8'h00, 6'b111111, acc1);
    drive(0, 8'hFF, 6'b000000, 1'b0);
    repeat (4) @(negedge clk);
    drive(0, 8'hFF, 6'b000000, 1'b1);
    chk("busy_ready_low", int'(ifa.in_ready), 0);
    @(negedge clk);
    drive(0, 8'hFF, 6'b000000, 1'b0);
    wait_done(0);
    repeat (70) @(negedge clk);
    chk("busy_single_latch", nlatch[0] - l0, 1);

    // Reset after the 7th shcp rise discards the frame
    base = nrise[0];
    l0 = nlatch[0];
    send(0, 8'h5A, 6'b010101, acc1);
    drive(0, 8'h5A, 6'b010101, 1'b0);
    for (int n = 0; n < 200 && nrise[0] - base < 7; n++) begin
      @(negedge clk);
      #1;
    end
    chk("mid_rises_before_reset", nrise[0] - base, 7);
    rst_n = 1'b0;
    #1;
    chk_reset_pins("mid");
    exp_bits[0].delete();
    exp_latch[0].delete();
    exp_done[0].delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_latch", nlatch[0] - l0, 0);
    base = nrise[0];
    send(0, 8'h81, 6'b011110, acc1);
    drive(0, 8'h81, 6'b011110, 1'b0);
    wait_done(0);
    chk("after_reset_full_frame", nrise[0] - base, 14);
    chk("after_reset_latched", nlatch[0] - l0, 1);

    // HALF=1 instance: period-2 shcp, 28-cycle SHIFT, 1-cycle stcp, done at +30
    @(negedge clk);
    send(1, 8'hC3, 6'b010101, acc1);
    drive(1, 8'hC3, 6'b010101, 1'b0);
    wait_done(1);
    chk("b_shift_len", last_rise[1] - acc1 - 1, 28);
    chk("b_latch_count", nlatch[1], 1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
